// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types, inverse S-box and GF(2^8) helpers for the AES decrypt core
package aes_pkg;

    localparam int KIDX_W = 4;

    // Byte 0 of the block (bits [127:120]) is element [15].
    typedef logic [15:0][7:0] state_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } fsm_t;

    // Row-major inverse S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    // Multiply by x modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_round_comb.sv
// rtl/inv_round_comb.sv - one combinational AES inverse round (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns)
module inv_round_comb
    import aes_pkg::*;
(
    input  state_t state,
    input  state_t rk,
    input  logic   last,
    output state_t next_state
);

    state_t sub_b;
    state_t ark_b;
    state_t mix_b;

    // Byte i sits at row i%4, column i/4; row r rotates right by r columns.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sub_b[15 - (4 * c + r)] = inv_sbox(state[15 - (4 * ((c - r + 4) % 4) + r)]);
        end

        assign mix_b[15 - 4 * c] = gmul14(ark_b[15 - 4 * c]) ^ gmul11(ark_b[14 - 4 * c])
                                 ^ gmul13(ark_b[13 - 4 * c]) ^ gmul9(ark_b[12 - 4 * c]);
        assign mix_b[14 - 4 * c] = gmul9(ark_b[15 - 4 * c])  ^ gmul14(ark_b[14 - 4 * c])
                                 ^ gmul11(ark_b[13 - 4 * c]) ^ gmul13(ark_b[12 - 4 * c]);
        assign mix_b[13 - 4 * c] = gmul13(ark_b[15 - 4 * c]) ^ gmul9(ark_b[14 - 4 * c])
                                 ^ gmul14(ark_b[13 - 4 * c]) ^ gmul11(ark_b[12 - 4 * c]);
        assign mix_b[12 - 4 * c] = gmul11(ark_b[15 - 4 * c]) ^ gmul13(ark_b[14 - 4 * c])
                                 ^ gmul9(ark_b[13 - 4 * c])  ^ gmul14(ark_b[12 - 4 * c]);
    end

    assign ark_b      = sub_b ^ rk;
    assign next_state = last ? ark_b : mix_b;

endmodule

// File: rtl/aes_decrypt_core.sv
// rtl/aes_decrypt_core.sv - iterative AES inverse cipher, one round per clock, keys fetched by index
module aes_decrypt_core
    import aes_pkg::*;
#(
    parameter int NR = 10
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_data,
    output logic [KIDX_W-1:0]   rk_idx,
    input  logic [127:0]        rk_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic                busy
);

    localparam logic [KIDX_W-1:0] NR_IDX   = KIDX_W'(NR);
    localparam logic [KIDX_W-1:0] LAST_IDX = KIDX_W'(NR - 1);

    fsm_t              fsm, fsm_nxt;
    logic [KIDX_W-1:0] rnd, rnd_nxt;
    state_t            state_reg, state_nxt;
    state_t            round_out;
    logic              load_out;
    logic              accept;

    inv_round_comb u_round (
        .state      (state_reg),
        .rk         (rk_data),
        .last       (rnd == '0),
        .next_state (round_out)
    );

    // Key index depends only on registered state so the key store sees a stable address.
    assign rk_idx    = (fsm == ROUND) ? rnd : NR_IDX;
    assign in_ready  = (fsm == IDLE) && !rst;
    assign out_valid = (fsm == DONE);
    assign busy      = (fsm != IDLE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        fsm_nxt   = fsm;
        rnd_nxt   = rnd;
        state_nxt = state_reg;
        load_out  = 1'b0;
        case (fsm)
            IDLE: begin
                if (accept) begin
                    state_nxt = in_data ^ rk_data;
                    rnd_nxt   = LAST_IDX;
                    fsm_nxt   = ROUND;
                end
            end
            ROUND: begin
                state_nxt = round_out;
                if (rnd == '0) begin
                    load_out = 1'b1;
                    fsm_nxt  = DONE;
                end else begin
                    rnd_nxt = rnd - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_nxt = IDLE;
                end
            end
            default: begin
                fsm_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            rnd       <= '0;
            state_reg <= '0;
            out_data  <= '0;
        end else begin
            fsm       <= fsm_nxt;
            rnd       <= rnd_nxt;
            state_reg <= state_nxt;
            if (load_out) begin
                out_data <= round_out;
            end
        end
    end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// tb/tb_aes_decrypt_core.sv - scoreboard bench for aes_decrypt_core with NR=10 and NR=14 builds
module tb_aes_decrypt_core;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [127:0] in_data   [2];
    logic [3:0]   rk_idx    [2];
    logic [127:0] rk_data   [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [127:0] out_data  [2];
    logic         busy      [2];
    logic [127:0] rk_tab    [2][16];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int           dut;
        logic [127:0] pt;
        int           acc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rk_data[0] = rk_tab[0][rk_idx[0]];
    assign rk_data[1] = rk_tab[1][rk_idx[1]];

    aes_decrypt_core #(.NR(10)) u_dut10 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_data   (in_data[0]),
        .rk_idx    (rk_idx[0]),
        .rk_data   (rk_data[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_data  (out_data[0]),
        .busy      (busy[0])
    );

    aes_decrypt_core #(.NR(14)) u_dut14 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_data   (in_data[1]),
        .rk_idx    (rk_idx[1]),
        .rk_data   (rk_data[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_data  (out_data[1]),
        .busy      (busy[1])
    );

    function automatic int nr_of(input int d);
        return (d == 0) ? 10 : 14;
    endfunction

    function automatic logic [7:0] fsb(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {fsb(w[31:24]), fsb(w[23:16]), fsb(w[15:8]), fsb(w[7:0])};
    endfunction

    // Forward key schedule fills the key-store model for one DUT.
    task automatic expand(input int d, input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i - nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= nr) rk_tab[d][r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
            else         rk_tab[d][r] = '0;
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Offer a block and wait (bounded) for acceptance; in_valid is left high.
    task automatic send(input int d, input logic [127:0] ct, input logic [127:0] pt,
                        input bit expect_out, output int acc);
        exp_t e;
        int   n;
        n           = 0;
        in_valid[d] = 1'b1;
        in_data[d]  = ct;
        @(negedge clk);
        while (!in_ready[d] && n < 40) begin
            n++;
            @(negedge clk);
        end
        acc = cyc + 1;
        if (!in_ready[d]) begin
            fail_now("accept_timeout");
            acc = -1;
        end else if (expect_out) begin
            e.dut = d;
            e.pt  = pt;
            e.acc = acc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int lim);
        int n;
        n = 0;
        while (sb.size() != 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            fail_now("drain_timeout");
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    logic         pv [2];
    logic         pr [2];
    logic [127:0] pd [2];

    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                pv[d] = 1'b0;
                pr[d] = 1'b0;
            end else begin
                if (pv[d] && !pr[d]) begin
                    chk("hold_valid", 128'(out_valid[d]), 128'd1);
                    chk("hold_data", out_data[d], pd[d]);
                end
                if (out_valid[d]) chk("in_ready_in_done", 128'(in_ready[d]), 128'd0);
                if (out_valid[d] && !pv[d]) begin
                    if (sb.size() == 0 || sb[0].dut != d) fail_now("unexpected_out_valid");
                    else chk("latency", 128'(cyc - sb[0].acc), 128'(nr_of(d)));
                end
                if (out_valid[d] && out_ready[d] && sb.size() != 0 && sb[0].dut == d) begin
                    e = sb.pop_front();
                    chk("plaintext", out_data[d], e.pt);
                end
                pv[d] = out_valid[d];
                pr[d] = out_ready[d];
                pd[d] = out_data[d];
            end
        end
    end

    initial begin
        int acc1;
        int acc2;
        int n;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = '0;
            out_ready[d] = 1'b1;
        end
        expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        expand(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
        chk("key_sched_c1_rk10", rk_tab[0][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk("key_sched_c3_rk14", rk_tab[1][14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_ready", 128'(in_ready[d]), 128'd0);
            chk("rst_out_valid", 128'(out_valid[d]), 128'd0);
            chk("rst_out_data", out_data[d], 128'd0);
            chk("rst_busy", 128'(busy[d]), 128'd0);
            chk("rst_rk_idx", 128'(rk_idx[d]), 128'(nr_of(d)));
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready10", 128'(in_ready[0]), 128'd1);
        chk("post_rst_in_ready14", 128'(in_ready[1]), 128'd1);
        @(posedge clk);
        #1;

        // C.1 with round-key index walk
        send(0, CT_C1, PT, 1'b1, acc1);
        in_valid[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("rk_idx_seq", 128'(rk_idx[0]), 128'(9 - k));
        end
        drain(10);

        // Backpressure: held for 5 cycles with in_valid still asserted
        out_ready[0] = 1'b0;
        send(0, CT_C1, PT, 1'b1, acc1);
        n = 0;
        while (!out_valid[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid[0]) fail_now("bp_valid_timeout");
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        drain(5);
        chk("bp_busy_after", 128'(busy[0]), 128'd0);

        // Back-to-back with in_valid held continuously
        send(0, CT_C1, PT, 1'b1, acc1);
        send(0, CT_C1, PT, 1'b1, acc2);
        in_valid[0] = 1'b0;
        chk("b2b_interval", 128'(acc2 - acc1), 128'd12);
        drain(30);

        // Reset pulsed mid-round
        send(0, CT_C1, PT, 1'b0, acc1);
        in_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready_low", 128'(in_ready[0]), 128'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 128'(in_ready[0]), 128'd1);
        chk("midrst_out_valid", 128'(out_valid[0]), 128'd0);
        chk("midrst_out_data", out_data[0], 128'd0);
        chk("midrst_busy", 128'(busy[0]), 128'd0);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1;
        send(0, CT_C1, PT, 1'b1, acc1);
        in_valid[0] = 1'b0;
        drain(20);

        // NR=14 build, FIPS-197 C.3
        send(1, CT_C3, PT, 1'b1, acc1);
        in_valid[1] = 1'b0;
        drain(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
